// File: rtl/stage_ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes and multiplier FSM states.
package ex_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/stage_ex_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per enabled cycle, low DATA_WIDTH bits kept.
module ex_mul_iter import ex_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(DATA_WIDTH);

    mul_state_t            state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] a_q, b_q, acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     if (cnt == CW'(DATA_WIDTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
        end else if (enable) begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    a_q <= a;
                    b_q <= b;
                    acc <= '0;
                    cnt <= '0;
                end
                MUL: begin
                    if (b_q[0]) acc <= acc + a_q;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == MUL);
    assign done    = (state == DONE);
    assign product = acc;

endmodule

// File: rtl/stage_ex.sv
// Execute stage: ALU, branch resolve, iterative MUL with upstream stall, EX/MEM register.
// Optional operand forwarding (EX/MEM > WB > ID/EX) enabled by defining STAGE_EX_FWD_EN.
module stage_ex import ex_pkg::*; #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH  = 4,
    parameter int unsigned IMEM_ADDR_WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [DATA_WIDTH-1:0]      r1_data_in,
    input  logic [DATA_WIDTH-1:0]      r2_data_in,
    input  logic [DATA_WIDTH-1:0]      imm32_in,
    input  logic                       use_imm_in,
    input  logic [REG_ADDR_WIDTH-1:0]  rs1_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0]  rs2_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_addr_in,
    input  logic [3:0]                 alu_ctrl_in,
    input  logic                       reg_wen_in,
    input  logic                       mem_wen_in,
    input  logic                       is_mem_inst_in,
    input  logic                       is_load_in,
    input  logic                       is_branch_in,
    input  logic                       is_jump_in,
    input  logic [IMEM_ADDR_WIDTH-1:0] branch_target_in,
    input  logic                       wb_wen_in,
    input  logic [REG_ADDR_WIDTH-1:0]  wb_addr_in,
    input  logic [DATA_WIDTH-1:0]      wb_data_in,
    output logic [DATA_WIDTH-1:0]      alu_result_out,
    output logic [DATA_WIDTH-1:0]      store_data_out,
    output logic [REG_ADDR_WIDTH-1:0]  rd_addr_out,
    output logic                       reg_wen_out,
    output logic                       mem_wen_out,
    output logic                       is_mem_inst_out,
    output logic                       is_load_out,
    output logic                       redirect_out,
    output logic [IMEM_ADDR_WIDTH-1:0] redirect_pc_out,
    output logic                       stall_out
);

    logic [DATA_WIDTH-1:0] op_a, op_b_reg, op_bsel, alu_res, mul_product;
    logic [4:0]            shamt;
    logic                  op_valid, is_mul, mul_busy, mul_done, taken, ctrl_flow;
    logic                  unused_sig;

`ifdef STAGE_EX_FWD_EN
    always_comb begin
        op_a = r1_data_in;
        if (reg_wen_out && rd_addr_out == rs1_addr_in)   op_a = alu_result_out;
        else if (wb_wen_in && wb_addr_in == rs1_addr_in) op_a = wb_data_in;
        op_b_reg = r2_data_in;
        if (reg_wen_out && rd_addr_out == rs2_addr_in)   op_b_reg = alu_result_out;
        else if (wb_wen_in && wb_addr_in == rs2_addr_in) op_b_reg = wb_data_in;
    end
    assign unused_sig = mul_busy;
`else
    assign op_a       = r1_data_in;
    assign op_b_reg   = r2_data_in;
    assign unused_sig = ^{mul_busy, wb_wen_in, wb_addr_in, wb_data_in, rs1_addr_in, rs2_addr_in};
`endif

    assign op_bsel = use_imm_in ? imm32_in : op_b_reg;
    assign shamt   = op_bsel[4:0];
    assign is_mul  = (alu_ctrl_in == ALU_MUL);

    // Operands are captured post-forwarding on the IDLE->MUL edge and held internally.
    ex_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (is_mul),
        .a       (op_a),
        .b       (op_bsel),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign stall_out = is_mul & ~mul_done;

    always_comb begin
        alu_res  = '0;
        op_valid = 1'b1;
        case (alu_ctrl_in)
            ALU_ADD:   alu_res = op_a + op_bsel;
            ALU_SUB:   alu_res = op_a - op_bsel;
            ALU_AND:   alu_res = op_a & op_bsel;
            ALU_OR:    alu_res = op_a | op_bsel;
            ALU_XOR:   alu_res = op_a ^ op_bsel;
            ALU_SLL:   alu_res = op_a << shamt;
            ALU_SRL:   alu_res = op_a >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_bsel)};
            ALU_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a < op_bsel};
            ALU_MUL:   alu_res = mul_product;
            ALU_PASSB: alu_res = op_bsel;
            default:   op_valid = 1'b0;
        endcase
    end

    assign taken           = is_branch_in & (op_a == op_bsel);
    assign ctrl_flow       = is_branch_in | is_jump_in;
    assign redirect_out    = enable & (taken | is_jump_in);
    assign redirect_pc_out = redirect_out ? branch_target_in : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_out  <= '0;
            store_data_out  <= '0;
            rd_addr_out     <= '0;
            reg_wen_out     <= 1'b0;
            mem_wen_out     <= 1'b0;
            is_mem_inst_out <= 1'b0;
            is_load_out     <= 1'b0;
        end else if (enable) begin
            if (stall_out) begin
                alu_result_out  <= '0;
                store_data_out  <= '0;
                rd_addr_out     <= '0;
                reg_wen_out     <= 1'b0;
                mem_wen_out     <= 1'b0;
                is_mem_inst_out <= 1'b0;
                is_load_out     <= 1'b0;
            end else begin
                alu_result_out  <= alu_res;
                store_data_out  <= op_b_reg;
                rd_addr_out     <= rd_addr_in;
                reg_wen_out     <= reg_wen_in & op_valid & ~ctrl_flow;
                mem_wen_out     <= mem_wen_in & ~ctrl_flow;
                is_mem_inst_out <= is_mem_inst_in;
                is_load_out     <= is_load_in;
            end
        end
    end

endmodule
